// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Pixel-rate VGA raster generator. Divides clk into a pixel
//                strobe, walks col/row over the full raster, and produces
//                registered hsync/vsync and blanked RGB that trail the
//                coordinates by exactly one pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] color_r,
    input  logic [CW-1:0] color_g,
    input  logic [CW-1:0] color_b,
    output logic          pix_ce,
    output logic [11:0]   row,
    output logic [11:0]   col,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_SUB_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [c_SUB_W-1:0] c_SUB_MAX = c_SUB_W'(PIX_DIV - 1);
    localparam logic [11:0]        c_H_LAST  = 12'(c_H_TOTAL - 1);
    localparam logic [11:0]        c_V_LAST  = 12'(c_V_TOTAL - 1);

    // Segment bounds are 13 bits wide so a raster of exactly 4096 still compares correctly
    localparam logic [12:0] c_H_ACT      = 13'(H_ACTIVE);
    localparam logic [12:0] c_V_ACT      = 13'(V_ACTIVE);
    localparam logic [12:0] c_HS_START   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] c_HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] c_VS_START   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] c_VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        c_HS_ON      = (HS_POL != 0);
    localparam logic        c_VS_ON      = (VS_POL != 0);

    logic [c_SUB_W-1:0] r_sub;
    logic [11:0]        r_col;
    logic [11:0]        r_row;
    logic [15:0]        r_frame_count;
    logic               r_hsync;
    logic               r_vsync;
    logic [CW-1:0]      r_red;
    logic [CW-1:0]      r_green;
    logic [CW-1:0]      r_blue;

    logic               w_pix_ce;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_active;
    logic               w_hs_zone;
    logic               w_vs_zone;
    logic [12:0]        w_col_x;
    logic [12:0]        w_row_x;

    // Pixel strobe and raster position decode from the current counters
    always_comb begin
        w_col_x    = {1'b0, r_col};
        w_row_x    = {1'b0, r_row};
        w_pix_ce   = en && (r_sub == c_SUB_MAX);
        w_col_last = (r_col == c_H_LAST);
        w_row_last = (r_row == c_V_LAST);
        w_active   = (w_row_x < c_V_ACT) && (w_col_x < c_H_ACT);
        w_hs_zone  = (w_col_x >= c_HS_START) && (w_col_x < c_HS_END);
        w_vs_zone  = (w_row_x >= c_VS_START) && (w_row_x < c_VS_END);
    end

    // Sub-pixel divider: advances only while enabled, so a pause resumes mid-pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= '0;
        end else if (en) begin
            r_sub <= (r_sub == c_SUB_MAX) ? '0 : r_sub + 1'b1;
        end
    end

    // Column/row raster counters and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_frame_count <= '0;
        end else if (w_pix_ce) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? 12'd0 : r_row + 12'd1;
                if (w_row_last) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end else begin
                r_col <= r_col + 12'd1;
            end
        end
    end

    // Sync and blanked video captured from the pixel being strobed, one pixel behind col/row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~c_HS_ON;
            r_vsync <= ~c_VS_ON;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_pix_ce) begin
            r_hsync <= w_hs_zone ? c_HS_ON : ~c_HS_ON;
            r_vsync <= w_vs_zone ? c_VS_ON : ~c_VS_ON;
            r_red   <= w_active ? color_r : '0;
            r_green <= w_active ? color_g : '0;
            r_blue  <= w_active ? color_b : '0;
        end
    end

    assign pix_ce      = w_pix_ce;
    assign row         = r_row;
    assign col         = r_col;
    assign active      = w_active;
    assign line_start  = w_pix_ce && (r_col == 12'd0);
    assign frame_start = w_pix_ce && (r_col == 12'd0) && (r_row == 12'd0);
    assign frame_count = r_frame_count;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Scoreboard bench for vga_timing. Instance 0 uses the default
//                640x480 timing, instance 1 a tiny raster (PIX_DIV=1,
//                HS_POL=1, H=8/1/2/1, V=4/1/1/1) so whole frames fit in a
//                short run. Expected outputs come from a pixel-index model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing;

    typedef struct {
        int pd, ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hpol, vpol;
    } cfg_t;

    typedef struct {
        logic        pix_ce;
        logic [11:0] row;
        logic [11:0] col;
        logic        active;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
        logic        hs;
        logic        vs;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [2:0]  b;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0;
    logic en1 = 1'b0;
    logic [2:0] cr = 3'd0;
    logic [2:0] cg = 3'd0;
    logic [2:0] cb = 3'd0;

    logic        pix_ce0, active0, ls0, fs0, hs0, vs0;
    logic [11:0] row0, col0;
    logic [15:0] fc0;
    logic [2:0]  r0, g0, b0;
    logic        pix_ce1, active1, ls1, fs1, hs1, vs1;
    logic [11:0] row1, col1;
    logic [15:0] fc1;
    logic [2:0]  r1, g1, b1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vga_timing u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0),
        .color_r(cr), .color_g(cg), .color_b(cb),
        .pix_ce(pix_ce0), .row(row0), .col(col0), .active(active0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0),
        .hsync(hs0), .vsync(vs0), .red(r0), .green(g0), .blue(b0)
    );

    vga_timing #(
        .PIX_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CW(3)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1),
        .color_r(cr), .color_g(cg), .color_b(cb),
        .pix_ce(pix_ce1), .row(row1), .col(col1), .active(active1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1),
        .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1)
    );

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        if (i == 0) c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
        else        c = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1, 0};
        return c;
    endfunction

    // Model state: enabled-clock count and strobed-pixel count since reset,
    // plus the values last captured into the registered outputs.
    longint     m_n  [2];
    longint     m_p  [2];
    logic       m_hs [2];
    logic       m_vs [2];
    logic [2:0] m_r  [2];
    logic [2:0] m_g  [2];
    logic [2:0] m_b  [2];

    obs_t q0[$];
    obs_t q1[$];

    task automatic model_reset(input int i);
        cfg_t c = get_cfg(i);
        m_n[i]  = 0;
        m_p[i]  = 0;
        m_hs[i] = (c.hpol == 0);
        m_vs[i] = (c.vpol == 0);
        m_r[i]  = 3'd0;
        m_g[i]  = 3'd0;
        m_b[i]  = 3'd0;
    endtask

    function automatic obs_t model_expect(input int i, input logic e);
        cfg_t   c  = get_cfg(i);
        longint ht = longint'(c.ha + c.hfp + c.hsy + c.hbp);
        longint vt = longint'(c.va + c.vfp + c.vsy + c.vbp);
        longint cv;
        longint rv;
        obs_t   o;
        cv       = m_p[i] % ht;
        rv       = (m_p[i] / ht) % vt;
        o.pix_ce = e && ((m_n[i] % longint'(c.pd)) == longint'(c.pd - 1));
        o.col    = 12'(cv);
        o.row    = 12'(rv);
        o.active = (rv < longint'(c.va)) && (cv < longint'(c.ha));
        o.ls     = o.pix_ce && (cv == 0);
        o.fs     = o.ls && (rv == 0);
        o.fc     = 16'((m_p[i] / (ht * vt)) % 65536);
        o.hs     = m_hs[i];
        o.vs     = m_vs[i];
        o.r      = m_r[i];
        o.g      = m_g[i];
        o.b      = m_b[i];
        return o;
    endfunction

    task automatic model_advance(input int i, input logic e);
        cfg_t c = get_cfg(i);
        obs_t o = model_expect(i, e);
        int   cv = int'(o.col);
        int   rv = int'(o.row);
        if (e) begin
            if (o.pix_ce) begin
                m_hs[i] = (cv >= c.ha + c.hfp && cv < c.ha + c.hfp + c.hsy) ? (c.hpol != 0) : (c.hpol == 0);
                m_vs[i] = (rv >= c.va + c.vfp && rv < c.va + c.vfp + c.vsy) ? (c.vpol != 0) : (c.vpol == 0);
                m_r[i]  = o.active ? cr : 3'd0;
                m_g[i]  = o.active ? cg : 3'd0;
                m_b[i]  = o.active ? cb : 3'd0;
                m_p[i]++;
            end
            m_n[i]++;
        end
    endtask

    function automatic obs_t sample(input int i);
        obs_t o;
        if (i == 0) o = '{pix_ce0, row0, col0, active0, ls0, fs0, fc0, hs0, vs0, r0, g0, b0};
        else        o = '{pix_ce1, row1, col1, active1, ls1, fs1, fc1, hs1, vs1, r1, g1, b1};
        return o;
    endfunction

    task automatic chk(input string nm, input int i, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", nm, i, $time, act, req);
    endtask

    task automatic compare(input int i, input obs_t x, input obs_t a);
        chk("pix_ce",      i, longint'(a.pix_ce), longint'(x.pix_ce));
        chk("row",         i, longint'(a.row),    longint'(x.row));
        chk("col",         i, longint'(a.col),    longint'(x.col));
        chk("active",      i, longint'(a.active), longint'(x.active));
        chk("line_start",  i, longint'(a.ls),     longint'(x.ls));
        chk("frame_start", i, longint'(a.fs),     longint'(x.fs));
        chk("frame_count", i, longint'(a.fc),     longint'(x.fc));
        chk("hsync",       i, longint'(a.hs),     longint'(x.hs));
        chk("vsync",       i, longint'(a.vs),     longint'(x.vs));
        chk("red",         i, longint'(a.r),      longint'(x.r));
        chk("green",       i, longint'(a.g),      longint'(x.g));
        chk("blue",        i, longint'(a.b),      longint'(x.b));
    endtask

    // One clock of stimulus: apply inputs just after the edge, queue what the
    // outputs must read for the rest of this cycle, then advance the model.
    task automatic step(input logic e0, input logic e1, input logic rst_a);
        obs_t x;
        @(posedge clk);
        #1;
        rst_n = ~rst_a;
        en0   = e0;
        en1   = e1;
        cr    = 3'($urandom);
        cg    = 3'($urandom);
        cb    = 3'($urandom);
        if (rst_a) begin
            model_reset(0);
            model_reset(1);
        end
        x = model_expect(0, e0);
        q0.push_back(x);
        x = model_expect(1, e1);
        q1.push_back(x);
        if (!rst_a) begin
            model_advance(0, e0);
            model_advance(1, e1);
        end
    endtask

    function automatic logic rnd_en();
        return ($urandom_range(0, 9) < 8);
    endfunction

    // Monitor: every falling edge, pop the expected cycle for each instance and compare
    initial begin
        obs_t x;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                x = q0.pop_front();
                compare(0, x, sample(0));
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                compare(1, x, sample(1));
            end
        end
    end

    initial begin
        int k;
        model_reset(0);
        model_reset(1);

        // Power-on reset, then release with both instances enabled
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);

        // Default instance runs continuously up to col 100
        k = 0;
        while (m_p[0] < 100 && k < 400) begin
            step(1'b1, rnd_en(), 1'b0);
            k++;
        end
        if (m_p[0] < 100) begin
            n_total++;
            $display("FAIL reach_col100 inst0 actual=%0d required=100", m_p[0]);
        end

        // Pause the default instance for 37 clocks, then resume
        for (int i = 0; i < 37; i++) step(1'b0, rnd_en(), 1'b0);
        for (int i = 0; i < 3500; i++) step(1'b1, rnd_en(), 1'b0);
        for (int i = 0; i < 400; i++) step(rnd_en(), rnd_en(), 1'b0);

        // Drive the small instance to row 2, col 5, then reset mid-frame
        k = 0;
        while ((m_p[1] % 84) != 29 && k < 200) begin
            step(rnd_en(), 1'b1, 1'b0);
            k++;
        end
        if ((m_p[1] % 84) != 29) begin
            n_total++;
            $display("FAIL reach_mid_frame inst1 actual=%0d required=29", m_p[1] % 84);
        end
        step(1'b0, 1'b0, 1'b1);
        #1;
        chk("async_col",         1, longint'(col1), 0);
        chk("async_row",         1, longint'(row1), 0);
        chk("async_frame_count", 1, longint'(fc1),  0);
        chk("async_hsync",       1, longint'(hs1),  0);
        chk("async_vsync",       1, longint'(vs1),  1);
        chk("async_red",         1, longint'(r1),   0);
        chk("async_col",         0, longint'(col0), 0);
        chk("async_hsync",       0, longint'(hs0),  1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(rnd_en(), rnd_en(), 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
